// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue
// Purpose  : Decodes MIPS ALU instructions into a one-hot ALU command and
//            issues them through a 2-entry skid buffer (valid/ready on both sides).
// Config   : define ALU_ISSUE_STATS_EN to add the stat_issued/stat_stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue #(
    parameter int CNT_W        = 32,
    parameter int ILLEGAL_PASS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [31:0]      in_rs_val,
    input  logic [31:0]      in_rt_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [11:0]      alu_control,
    output logic [31:0]      alu_src1,
    output logic [31:0]      alu_src2,
    output logic [4:0]       out_dest,
    output logic             out_illegal
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_issued,
    output logic [CNT_W-1:0] stat_stall
`endif
);

    localparam logic [11:0] C_ADD  = 12'h800;
    localparam logic [11:0] C_SUB  = 12'h400;
    localparam logic [11:0] C_SLT  = 12'h200;
    localparam logic [11:0] C_SLTU = 12'h100;
    localparam logic [11:0] C_AND  = 12'h080;
    localparam logic [11:0] C_NOR  = 12'h040;
    localparam logic [11:0] C_OR   = 12'h020;
    localparam logic [11:0] C_XOR  = 12'h010;
    localparam logic [11:0] C_SLL  = 12'h008;
    localparam logic [11:0] C_SRL  = 12'h004;
    localparam logic [11:0] C_SRA  = 12'h002;
    localparam logic [11:0] C_LUI  = 12'h001;

    typedef struct packed {
        logic [11:0] ctrl;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [4:0]  dest;
        logic        illegal;
    } payload_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t   r_state;
    payload_t r_main;
    payload_t r_skid;
    payload_t w_new;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;
    logic [31:0] w_imm_sext;
    logic [31:0] w_imm_zext;
    logic        w_accept;
    logic        w_enq;
    logic        w_oxfer;
    logic        unused_rs_field;

    assign w_op            = in_inst[31:26];
    assign w_funct         = in_inst[5:0];
    assign w_imm           = in_inst[15:0];
    assign w_imm_sext      = {{16{w_imm[15]}}, w_imm};
    assign w_imm_zext      = {16'd0, w_imm};
    assign unused_rs_field = ^in_inst[25:21];

    always_comb begin
        w_new         = '0;
        w_new.illegal = 1'b0;
        if (w_op == 6'h00) begin
            w_new.src1 = in_rs_val;
            w_new.src2 = in_rt_val;
            w_new.dest = in_inst[15:11];
            case (w_funct)
                6'h20, 6'h21: w_new.ctrl = C_ADD;
                6'h22, 6'h23: w_new.ctrl = C_SUB;
                6'h2A:        w_new.ctrl = C_SLT;
                6'h2B:        w_new.ctrl = C_SLTU;
                6'h24:        w_new.ctrl = C_AND;
                6'h27:        w_new.ctrl = C_NOR;
                6'h25:        w_new.ctrl = C_OR;
                6'h26:        w_new.ctrl = C_XOR;
                6'h00: begin w_new.ctrl = C_SLL; w_new.src1 = {27'd0, in_inst[10:6]}; end
                6'h02: begin w_new.ctrl = C_SRL; w_new.src1 = {27'd0, in_inst[10:6]}; end
                6'h03: begin w_new.ctrl = C_SRA; w_new.src1 = {27'd0, in_inst[10:6]}; end
                6'h04:        w_new.ctrl = C_SLL;
                6'h06:        w_new.ctrl = C_SRL;
                6'h07:        w_new.ctrl = C_SRA;
                default:      w_new.illegal = 1'b1;
            endcase
        end else begin
            w_new.src1 = in_rs_val;
            w_new.dest = in_inst[20:16];
            case (w_op)
                6'h08, 6'h09: begin w_new.ctrl = C_ADD;  w_new.src2 = w_imm_sext; end
                6'h0A:        begin w_new.ctrl = C_SLT;  w_new.src2 = w_imm_sext; end
                6'h0B:        begin w_new.ctrl = C_SLTU; w_new.src2 = w_imm_sext; end
                6'h0C:        begin w_new.ctrl = C_AND;  w_new.src2 = w_imm_zext; end
                6'h0D:        begin w_new.ctrl = C_OR;   w_new.src2 = w_imm_zext; end
                6'h0E:        begin w_new.ctrl = C_XOR;  w_new.src2 = w_imm_zext; end
                6'h0F:        begin w_new.ctrl = C_LUI;  w_new.src2 = w_imm_zext; w_new.src1 = '0; end
                default:      w_new.illegal = 1'b1;
            endcase
        end
        // Illegal payloads carry nothing but the flag
        if (w_new.illegal) begin
            w_new         = '0;
            w_new.illegal = 1'b1;
        end
    end

    assign w_accept = in_valid & in_ready;
    assign w_enq    = w_accept & ((ILLEGAL_PASS != 0) | ~w_new.illegal);
    assign w_oxfer  = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_EMPTY;
            r_main    <= '0;
            r_skid    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_enq) begin
                        r_main    <= w_new;
                        r_state   <= ST_ONE;
                        out_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_oxfer && !w_enq) begin
                        r_state   <= ST_EMPTY;
                        out_valid <= 1'b0;
                    end else if (w_enq && !w_oxfer) begin
                        r_skid    <= w_new;
                        r_state   <= ST_TWO;
                        in_ready  <= 1'b0;
                    end else if (w_enq && w_oxfer) begin
                        r_main    <= w_new;
                    end
                end
                ST_TWO: begin
                    if (w_oxfer) begin
                        r_main    <= r_skid;
                        r_state   <= ST_ONE;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign alu_control = r_main.ctrl;
    assign alu_src1    = r_main.src1;
    assign alu_src2    = r_main.src2;
    assign out_dest    = r_main.dest;
    assign out_illegal = r_main.illegal;

`ifdef ALU_ISSUE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (w_oxfer)
                stat_issued <= stat_issued + 1'b1;
            if (out_valid && !out_ready)
                stat_stall  <= stat_stall + 1'b1;
        end
    end
`else
    localparam int UNUSED_CNT_W = CNT_W;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue
// Purpose  : Self-checking bench for alu_issue: directed vectors, back-pressure,
//            illegal handling, async reset and randomized scoreboard traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue;

    localparam int CNT_W = 32;
    localparam logic [5:0] RFUN [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h2A, 6'h2B, 6'h24,
                                         6'h27, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03, 6'h04};
    localparam logic [5:0] IOPS [8]  = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};

    typedef struct packed {
        logic [11:0] ctrl;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [4:0]  dest;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = '0;
    logic [31:0] in_rs_val = '0;
    logic [31:0] in_rt_val = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_illegal;
    logic [11:0] alu_control;
    logic [31:0] alu_src1, alu_src2;
    logic [4:0]  out_dest;

    logic        in_ready0, out_valid0, out_illegal0;
    logic [11:0] alu_control0;
    logic [31:0] alu_src10, alu_src20;
    logic [4:0]  out_dest0;

`ifdef ALU_ISSUE_STATS_EN
    logic [CNT_W-1:0] stat_issued, stat_stall, stat_issued0, stat_stall0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_issue #(.CNT_W(CNT_W), .ILLEGAL_PASS(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
        .out_valid(out_valid), .out_ready(out_ready), .alu_control(alu_control),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .out_dest(out_dest),
        .out_illegal(out_illegal)
`ifdef ALU_ISSUE_STATS_EN
        , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
    );

    alu_issue #(.CNT_W(CNT_W), .ILLEGAL_PASS(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .in_inst(in_inst), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
        .out_valid(out_valid0), .out_ready(out_ready), .alu_control(alu_control0),
        .alu_src1(alu_src10), .alu_src2(alu_src20), .out_dest(out_dest0),
        .out_illegal(out_illegal0)
`ifdef ALU_ISSUE_STATS_EN
        , .stat_issued(stat_issued0), .stat_stall(stat_stall0)
`endif
    );

    // Reference decode straight from the instruction-set rules
    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] rs, input logic [31:0] rt);
        exp_t        e;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [15:0] imm;
        e   = '0;
        op  = inst[31:26];
        fn  = inst[5:0];
        imm = inst[15:0];
        if (op == 6'h00) begin
            e.src1 = rs; e.src2 = rt; e.dest = inst[15:11];
            if (fn == 6'h20 || fn == 6'h21)      e.ctrl = 12'h800;
            else if (fn == 6'h22 || fn == 6'h23) e.ctrl = 12'h400;
            else if (fn == 6'h2A) e.ctrl = 12'h200;
            else if (fn == 6'h2B) e.ctrl = 12'h100;
            else if (fn == 6'h24) e.ctrl = 12'h080;
            else if (fn == 6'h27) e.ctrl = 12'h040;
            else if (fn == 6'h25) e.ctrl = 12'h020;
            else if (fn == 6'h26) e.ctrl = 12'h010;
            else if (fn == 6'h00 || fn == 6'h04) e.ctrl = 12'h008;
            else if (fn == 6'h02 || fn == 6'h06) e.ctrl = 12'h004;
            else if (fn == 6'h03 || fn == 6'h07) e.ctrl = 12'h002;
            else e.ill = 1'b1;
            if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03)
                e.src1 = 32'(inst[10:6]);
        end else begin
            e.src1 = rs; e.dest = inst[20:16];
            if (op == 6'h08 || op == 6'h09 || op == 6'h0A || op == 6'h0B)
                e.src2 = 32'($signed(imm));
            else
                e.src2 = 32'(imm);
            if (op == 6'h08 || op == 6'h09) e.ctrl = 12'h800;
            else if (op == 6'h0A) e.ctrl = 12'h200;
            else if (op == 6'h0B) e.ctrl = 12'h100;
            else if (op == 6'h0C) e.ctrl = 12'h080;
            else if (op == 6'h0D) e.ctrl = 12'h020;
            else if (op == 6'h0E) e.ctrl = 12'h010;
            else if (op == 6'h0F) begin e.ctrl = 12'h001; e.src1 = '0; end
            else e.ill = 1'b1;
        end
        if (e.ill) begin
            e = '0;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        int          sel;
        w   = $urandom;
        sel = $urandom_range(0, 9);
        if (sel < 5) begin
            w[31:26] = 6'h00;
            if (sel < 4) w[5:0] = RFUN[$urandom_range(0, 13)];
        end else if (sel < 9) begin
            w[31:26] = IOPS[$urandom_range(0, 7)];
        end
        return w;
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_control !== 12'h000 || alu_src1 !== 32'd0 ||
            alu_src2 !== 32'd0 || out_dest !== 5'd0 || out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got v=%b rdy=%b ctl=%h s1=%h s2=%h d=%0d ill=%b, need v=0 rdy=1 rest 0",
                     out_valid, in_ready, alu_control, alu_src1, alu_src2, out_dest, out_illegal);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] insts [4] = '{32'h2528FFFF, 32'h00031100, 32'h34228000, 32'h3C011234};
        logic [31:0] rsv   [4] = '{32'd5, 32'd0, 32'd0, 32'd0};
        logic [31:0] rtv   [4] = '{32'd0, 32'd1, 32'd0, 32'd0};
        logic [11:0] ctl   [4] = '{12'h800, 12'h008, 12'h020, 12'h001};
        logic [31:0] s1    [4] = '{32'd5, 32'd4, 32'd0, 32'd0};
        logic [31:0] s2    [4] = '{32'hFFFFFFFF, 32'd1, 32'h00008000, 32'h00001234};
        logic [4:0]  dst   [4] = '{5'd8, 5'd2, 5'd2, 5'd1};
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_inst = insts[i]; in_rs_val = rsv[i]; in_rt_val = rtv[i];
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || alu_control !== ctl[i] || alu_src1 !== s1[i] || alu_src2 !== s2[i] ||
                out_dest !== dst[i] || out_illegal !== 1'b0) begin
                errors++;
                $display("FAIL directed_%0d: got v=%b ctl=%h s1=%h s2=%h d=%0d ill=%b, need v=1 ctl=%h s1=%h s2=%h d=%0d ill=0",
                         i, out_valid, alu_control, alu_src1, alu_src2, out_dest, out_illegal,
                         ctl[i], s1[i], s2[i], dst[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL directed_drain: out_valid=%b need 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got [$];
        logic [31:0] want [3] = '{32'd11, 32'd22, 32'd33};
        logic        drop;
        drop = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1; in_inst = 32'h00221821; in_rt_val = 32'd0; in_rs_val = 32'd11;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_a: in_ready=%b need 1", in_ready); end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_b: in_ready=%b need 1", in_ready); end
        in_rs_val = 32'd22;
        @(negedge clk);
        in_rs_val = 32'd33;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || alu_src1 !== 32'd11) begin
                errors++;
                $display("FAIL b2b_stall_%0d: rdy=%b v=%b s1=%0d need rdy=0 v=1 s1=11", k, in_ready, out_valid, alu_src1);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (drop) in_valid = 1'b0;
            if (out_valid) got.push_back(alu_src1);
            if (in_valid && in_ready) drop = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d outputs need 3", got.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (got[k] !== want[k]) begin
                    errors++;
                    $display("FAIL b2b_order_%0d: got src1=%0d need %0d", k, got[k], want[k]);
                end
            end
        end
    endtask

    task automatic test_illegal();
        pulse_reset();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1; in_inst = 32'hFC000000; in_rs_val = 32'h1234; in_rt_val = 32'h5678;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_illegal !== 1'b1 || alu_control !== 12'h000 ||
            alu_src1 !== 32'd0 || alu_src2 !== 32'd0 || out_dest !== 5'd0) begin
            errors++;
            $display("FAIL illegal_pass: v=%b ill=%b ctl=%h s1=%h s2=%h d=%0d need v=1 ill=1 rest 0",
                     out_valid, out_illegal, alu_control, alu_src1, alu_src2, out_dest);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
                errors++;
                $display("FAIL illegal_drop_%0d: v=%b rdy=%b need v=0 rdy=1", k, out_valid0, in_ready0);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        exp_t             q [$];
        exp_t             e;
        logic             oxfer, acc;
        logic [CNT_W-1:0] n_issued, n_stall;
        n_issued = '0; n_stall = '0;
        pulse_reset();
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
                errors++;
                $display("FAIL rand_flags_c%0d: v=%b rdy=%b need v=%b rdy=%b", c, out_valid, in_ready,
                         q.size() > 0, q.size() < 2);
            end
            if (out_valid && q.size() > 0) begin
                checks++;
                if (alu_control !== q[0].ctrl || alu_src1 !== q[0].src1 || alu_src2 !== q[0].src2 ||
                    out_dest !== q[0].dest || out_illegal !== q[0].ill) begin
                    errors++;
                    $display("FAIL rand_payload_c%0d: got ctl=%h s1=%h s2=%h d=%0d ill=%b need ctl=%h s1=%h s2=%h d=%0d ill=%b",
                             c, alu_control, alu_src1, alu_src2, out_dest, out_illegal,
                             q[0].ctrl, q[0].src1, q[0].src2, q[0].dest, q[0].ill);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (!(in_valid && !in_ready) || $urandom_range(0, 3) == 0) begin
                in_valid  = ($urandom_range(0, 2) != 0);
                in_inst   = rand_inst();
                in_rs_val = $urandom;
                in_rt_val = $urandom;
            end
            oxfer = out_valid && out_ready;
            acc   = in_valid && in_ready;
            if (out_valid && !out_ready) n_stall++;
            if (oxfer) begin
                void'(q.pop_front());
                n_issued++;
            end
            if (acc) begin
                e = model(in_inst, in_rs_val, in_rt_val);
                q.push_back(e);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
`ifdef ALU_ISSUE_STATS_EN
        checks++;
        if (stat_issued !== n_issued || stat_stall !== n_stall) begin
            errors++;
            $display("FAIL rand_stats: issued=%0d stall=%0d need issued=%0d stall=%0d",
                     stat_issued, stat_stall, n_issued, n_stall);
        end
`endif
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_in_two();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1; in_inst = 32'h3C01ABCD; in_rs_val = 32'd7;
        @(negedge clk);
        in_inst = 32'h3421FFFF;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL two_setup: rdy=%b v=%b need rdy=0 v=1", in_ready, out_valid);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_control !== 12'h000 ||
            alu_src1 !== 32'd0 || alu_src2 !== 32'd0 || out_dest !== 5'd0) begin
            errors++;
            $display("FAIL two_async_reset: v=%b rdy=%b ctl=%h s1=%h s2=%h d=%0d need v=0 rdy=1 rest 0",
                     out_valid, in_ready, alu_control, alu_src1, alu_src2, out_dest);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL two_after_release: v=%b rdy=%b need v=0 rdy=1", out_valid, in_ready);
        end
`ifdef ALU_ISSUE_STATS_EN
        checks++;
        if (stat_issued !== '0 || stat_stall !== '0) begin
            errors++;
            $display("FAIL two_stats_cleared: issued=%0d stall=%0d need 0 0", stat_issued, stat_stall);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_illegal();
        test_random();
        test_reset_in_two();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
